// File: rtl/inst_mem_pkg.sv
// Shared constants and state encoding for the loadable instruction memory.
// The loader FSM state type is visible to the top and to any bound checker.
package inst_mem_pkg;

  localparam int unsigned BYTE_W = 8;

  // addi x0,x0,0 : a harmless NOP handed to the IF stage on a bad fetch.
  localparam logic [31:0] FAULT_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } ld_state_e;

endpackage : inst_mem_pkg

// File: rtl/inst_mem_loader.sv
// Programming-port controller: IDLE/LOAD/RUN FSM, byte write pointer,
// overflow flag and the write strobe into the byte array.
module inst_mem_loader
  import inst_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned IDX_W     = $clog2(MEM_DEPTH),
  parameter int unsigned CNT_W     = $clog2(MEM_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_en_i,
  input  logic              prog_valid_i,
  input  logic [BYTE_W-1:0] prog_byte_i,
  output logic              prog_ready_o,
  output logic [CNT_W-1:0]  prog_count_o,
  output logic              prog_ovf_o,
  output logic              we_o,
  output logic [IDX_W-1:0]  waddr_o,
  output logic [BYTE_W-1:0] wdata_o,
  output ld_state_e         state_o
);

  ld_state_e        state_q, state_d;
  logic [CNT_W-1:0] ptr_q, ptr_d;
  logic             ovf_q, ovf_d;
  logic             ready;
  logic             wr_en;

  // The pointer is one bit wider than the array index so "full" is ptr == MEM_DEPTH.
  assign ready = (state_q == ST_LOAD) && (ptr_q < CNT_W'(MEM_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (prog_en_i) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        // A byte offered on the cycle prog_en falls is still taken.
        if (prog_valid_i) begin
          if (ready) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (!prog_en_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (prog_en_i) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset wins over a byte offered in the same cycle.
  assign we_o         = wr_en && !rst;
  assign waddr_o      = ptr_q[IDX_W-1:0];
  assign wdata_o      = prog_byte_i;
  assign prog_ready_o = ready;
  assign prog_count_o = ptr_q;
  assign prog_ovf_o   = ovf_q;
  assign state_o      = state_q;

endmodule : inst_mem_loader

// File: rtl/inst_mem_loadable.sv
// Byte-addressed instruction memory with a streaming programming port and a
// registered little-endian fetch port (one-cycle req -> instr_valid).
//
// Handshakes:
//   prog:  a byte transfers on a rising edge where prog_valid=1 and prog_ready=1;
//          prog_valid while prog_ready=0 in LOAD drops the byte and sets prog_ovf.
//   fetch: a request is accepted on a rising edge where fetch_req=1 and
//          fetch_ready=1; the response appears exactly one cycle later with
//          instr_valid=1 for that one cycle. There is no back-pressure on results.
module inst_mem_loadable
  import inst_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned INSTR_BYTES = 4,
  parameter logic [8*INSTR_BYTES-1:0] FAULT_INSTR = (8*INSTR_BYTES)'(FAULT_INSTR_DEF)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        prog_en,
  input  logic                        prog_valid,
  input  logic [7:0]                  prog_byte,
  output logic                        prog_ready,
  output logic [$clog2(MEM_DEPTH):0]  prog_count,
  output logic                        prog_ovf,
  input  logic                        fetch_req,
  input  logic [ADDR_WIDTH-1:0]       fetch_addr,
  output logic                        fetch_ready,
  output logic                        instr_valid,
  output logic [8*INSTR_BYTES-1:0]    o_instr,
  output logic                        fetch_fault
);

  localparam int unsigned IDX_W   = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W   = IDX_W + 1;
  localparam int unsigned INSTR_W = BYTE_W * INSTR_BYTES;

  logic [BYTE_W-1:0] mem [MEM_DEPTH];

  logic              we;
  logic [IDX_W-1:0]  waddr;
  logic [BYTE_W-1:0] wdata;
  ld_state_e         ld_state;

  logic               accept;
  logic               misaligned;
  logic               out_of_range;
  logic               fault;
  logic [IDX_W-1:0]   base;
  logic [INSTR_W-1:0] rd_word;

  logic               valid_q, valid_d;
  logic               fault_q, fault_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  inst_mem_loader #(
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W),
    .CNT_W     (CNT_W)
  ) u_loader (
    .clk          (clk),
    .rst          (rst),
    .prog_en_i    (prog_en),
    .prog_valid_i (prog_valid),
    .prog_byte_i  (prog_byte),
    .prog_ready_o (prog_ready),
    .prog_count_o (prog_count),
    .prog_ovf_o   (prog_ovf),
    .we_o         (we),
    .waddr_o      (waddr),
    .wdata_o      (wdata),
    .state_o      (ld_state)
  );

  // Contents are deliberately not reset so a reboot can run the loaded image.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign fetch_ready = (ld_state == ST_RUN);
  assign accept      = fetch_req && fetch_ready;

  // Full-width compare: high address bits must not alias back into the array.
  assign misaligned   = (fetch_addr % ADDR_WIDTH'(INSTR_BYTES)) != '0;
  assign out_of_range = fetch_addr > ADDR_WIDTH'(MEM_DEPTH - INSTR_BYTES);
  assign fault        = misaligned || out_of_range;
  assign base         = fetch_addr[IDX_W-1:0];

  // Only meaningful when !fault, which guarantees base+i stays inside the array.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < INSTR_BYTES; i++) begin
      rd_word[BYTE_W*i +: BYTE_W] = mem[base + IDX_W'(i)];
    end
  end

  always_comb begin
    valid_d = accept;
    fault_d = fault_q;
    instr_d = instr_q;
    if (accept) begin
      fault_d = fault;
      instr_d = fault ? FAULT_INSTR : rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      fault_q <= fault_d;
      instr_q <= instr_d;
    end
  end

  assign instr_valid = valid_q;
  assign fetch_fault = fault_q;
  assign o_instr     = instr_q;

endmodule : inst_mem_loadable
